// File: rtl/kbd_pkg.sv
// Shared types and defaults for the key matrix scanner.
// The optional RELEASE_EVT_EN macro is consumed by key_matrix_scanner.
package kbd_pkg;

    typedef enum logic {
        S_SETTLE = 1'b0,
        S_SAMPLE = 1'b1
    } scan_state_t;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_SCAN_DIV = 16;
    localparam int DEF_DEB_MAX  = 3;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int kw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One saturating debounce integrator for a single key, plus the flag saying
// this sample would flip the key's committed state.
module key_debounce
    import kbd_pkg::*;
#(
    parameter int DEB_MAX = DEF_DEB_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_pressed,
    input  logic i_state,
    output logic o_cand
);

    localparam logic [3:0] MAX_V = 4'(DEB_MAX);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_en) begin
            if (i_pressed) begin
                if (r_cnt != MAX_V) w_cnt_next = r_cnt + 4'd1;
            end else begin
                if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= 4'd0;
        else        r_cnt <= w_cnt_next;
    end

    // Judged on the post-update value so the commit lands in the same sample.
    assign o_cand = i_en && (((w_cnt_next == MAX_V) && !i_state) ||
                             ((w_cnt_next == 4'd0) && i_state));

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-scanning key matrix reader with per-key debounce and a one-deep
// press/release event slot. Define RELEASE_EVT_EN to also report releases.
module key_matrix_scanner
    import kbd_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEB_MAX  = DEF_DEB_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ROWS-1:0]                row_in,
    output logic [COLS-1:0]                col_out,
    output logic [ROWS*COLS-1:0]           key_state,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [kw_of(ROWS*COLS)-1:0]    evt_code,
    output logic                           evt_press
);

    localparam int NK  = ROWS * COLS;
    localparam int KW  = kw_of(NK);
    localparam int CLW = kw_of(COLS);

    logic [ROWS-1:0]     r_row_meta;
    logic [ROWS-1:0]     r_row_sync;
    logic [ROWS-1:0]     w_row_pressed;
    logic [SCAN_DIV-1:0] r_presc;
    logic                w_tick;
    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic                w_sample;
    logic [CLW-1:0]      r_col;
    logic [NK-1:0]       r_key_state;
    logic [NK-1:0]       w_cand;
    logic [NK-1:0]       w_elig;
    logic                w_slot_free;
    logic                w_commit;
    logic                w_commit_rel;
    logic [KW-1:0]       w_commit_idx;
    logic                w_load;
    logic                r_evt_valid;
    logic [KW-1:0]       r_evt_code;

    // Rows idle high through the pull-ups, so the synchroniser resets to "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_row_pressed = ~r_row_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_presc <= '0;
        else        r_presc <= r_presc + 1'b1;
    end

    assign w_tick = &r_presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SETTLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SETTLE: if (w_tick) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = S_SETTLE;
            default:  w_state_next = S_SETTLE;
        endcase
    end

    assign w_sample = (r_state == S_SAMPLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
        end else if (w_sample) begin
            r_col <= (r_col == CLW'(COLS - 1)) ? '0 : r_col + 1'b1;
        end
    end

    assign col_out = ~(COLS'(1) << r_col);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            for (genvar gj = 0; gj < COLS; gj++) begin : g_col
                key_debounce #(
                    .DEB_MAX (DEB_MAX)
                ) u_deb (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .i_en      (w_sample && (r_col == CLW'(gj))),
                    .i_pressed (w_row_pressed[gi]),
                    .i_state   (r_key_state[gi*COLS+gj]),
                    .o_cand    (w_cand[gi*COLS+gj])
                );
            end
        end
    endgenerate

    assign w_slot_free = !r_evt_valid || evt_ready;

    // Only the sampled column can raise candidates, so the lowest key index is the lowest row.
    generate
        for (genvar gi = 0; gi < NK; gi++) begin : g_elig
`ifdef RELEASE_EVT_EN
            assign w_elig[gi] = w_cand[gi] && w_slot_free;
`else
            assign w_elig[gi] = w_cand[gi] && (w_slot_free || r_key_state[gi]);
`endif
        end
    endgenerate

    always_comb begin
        w_commit     = 1'b0;
        w_commit_rel = 1'b0;
        w_commit_idx = '0;
        for (int k = NK - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_commit     = 1'b1;
                w_commit_rel = r_key_state[k];
                w_commit_idx = KW'(k);
            end
        end
    end

`ifdef RELEASE_EVT_EN
    assign w_load = w_commit;
`else
    assign w_load = w_commit && !w_commit_rel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_state <= '0;
        end else if (w_commit) begin
            r_key_state <= r_key_state ^ (NK'(1) << w_commit_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_code  <= w_commit_idx;
        end else if (evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

`ifdef RELEASE_EVT_EN
    logic r_evt_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_evt_press <= 1'b0;
        else if (w_load) r_evt_press <= !w_commit_rel;
    end

    assign evt_press = r_evt_press;
`else
    assign evt_press = 1'b1;
`endif

    assign key_state = r_key_state;
    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;

endmodule
